// File: rtl/dds_waveform_gen.sv
// dds_waveform_gen: DDS phase accumulator, shape synthesis, amplitude scaling and DAC valid/ready port.
// Define DDS_SYNC_UPDATE_EN to reload shadow parameters only on phase wrap instead of on every tick.
module dds_waveform_gen #(
   parameter int PHASE_BIT = 12,
   parameter int DAC_BIT   = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PHASE_BIT-2:0] phase_M,
   input  logic [DAC_BIT-2:0]   signal_A,
   input  logic [1:0]           signal_shape,
   input  logic                 sample_tick,
   output logic [PHASE_BIT-1:0] rom_addr,
   input  logic [DAC_BIT-1:0]   rom_data,
   output logic [DAC_BIT-1:0]   dac_data,
   output logic                 dac_valid,
   input  logic                 dac_ready,
   output logic                 phase_wrap,
   output logic                 sample_overrun
);
   localparam int P = PHASE_BIT;
   localparam int D = DAC_BIT;
   localparam logic [D-1:0] MID   = {1'b1, {(D-1){1'b0}}};
   localparam logic [D-1:0] FULL  = {1'b0, {(D-1){1'b1}}};
   localparam logic [D-1:0] NFULL = {1'b1, {(D-2){1'b0}}, 1'b1};

   logic [P-1:0]   acc_q, acc_d;
   logic [P-2:0]   m_q, m_d;
   logic [D-2:0]   a_q, a_d, s1_a_q, s1_a_d, s2_a_q, s2_a_d;
   logic [1:0]     shape_q, shape_d, s1_shape_q, s1_shape_d, s2_shape_q, s2_shape_d;
   logic           s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [D-1:0]   s2_w_q, s2_w_d, dac_data_q, dac_data_d;
   logic           dac_valid_q, dac_valid_d, wrap_q, wrap_d, ovr_q, ovr_d;
   logic [P:0]     sum;
   logic           accept, load;
   logic [P-2:0]   ramp;
   logic [D-2:0]   ramp_j;
   logic [D-1:0]   tri_w, sq_w, w;
   logic [2*D-1:0] prod;

   always_comb begin
      sum         = {1'b0, acc_q} + {2'b00, m_q};
      accept      = sample_tick && !s1_valid_q && !s2_valid_q && (!dac_valid_q || dac_ready);
`ifdef DDS_SYNC_UPDATE_EN
      load        = (m_q == '0) || (accept && sum[P]);
`else
      load        = (m_q == '0) || accept;
`endif
      acc_d       = accept ? sum[P-1:0] : acc_q;
      wrap_d      = accept && sum[P];
      ovr_d       = ovr_q || (sample_tick && !accept);
      m_d         = load ? phase_M : m_q;
      a_d         = load ? signal_A : a_q;
      shape_d     = load ? signal_shape : shape_q;
      s1_valid_d  = accept;
      s1_a_d      = accept ? a_q : s1_a_q;
      s1_shape_d  = accept ? shape_q : s1_shape_q;
      // acc already holds the new phase by the time s1 moves to s2
      ramp        = acc_q[P-1] ? ~acc_q[P-2:0] : acc_q[P-2:0];
      ramp_j      = (D-1)'({ramp, {(D-1){1'b0}}} >> (P-1));
      tri_w       = {ramp_j, 1'b0} - FULL;
      sq_w        = acc_q[P-1] ? NFULL : FULL;
      s2_valid_d  = s1_valid_q;
      s2_a_d      = s1_valid_q ? s1_a_q : s2_a_q;
      s2_shape_d  = s1_valid_q ? s1_shape_q : s2_shape_q;
      s2_w_d      = s1_valid_q ? (s1_shape_q == 2'd1 ? tri_w : s1_shape_q == 2'd2 ? sq_w : '0) : s2_w_q;
      w           = s2_shape_q == 2'd0 ? rom_data : s2_w_q;
      prod        = {{D{w[D-1]}}, w} * {{(D+1){1'b0}}, s2_a_q};
      dac_data_d  = s2_valid_q ? MID + D'($signed(prod) >>> (D-1)) : dac_data_q;
      dac_valid_d = s2_valid_q || (dac_valid_q && !dac_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         m_q         <= '0;
         a_q         <= '0;
         shape_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_shape_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_a_q      <= '0;
         s2_shape_q  <= '0;
         s2_w_q      <= '0;
         dac_data_q  <= MID;
         dac_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         m_q         <= m_d;
         a_q         <= a_d;
         shape_q     <= shape_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_shape_q  <= s1_shape_d;
         s2_valid_q  <= s2_valid_d;
         s2_a_q      <= s2_a_d;
         s2_shape_q  <= s2_shape_d;
         s2_w_q      <= s2_w_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         wrap_q      <= wrap_d;
         ovr_q       <= ovr_d;
      end
   end

   assign rom_addr       = acc_q;
   assign dac_data       = dac_data_q;
   assign dac_valid      = dac_valid_q;
   assign phase_wrap     = wrap_q;
   assign sample_overrun = ovr_q;
endmodule

// File: tb/tb_dds_waveform_gen.sv
// tb_dds_waveform_gen: directed test-plan cases plus randomized traffic against a sample-level model.
module tb_dds_waveform_gen;
   localparam int HALF = 2048;
   localparam int AMAX = 2047;
   localparam int MOD  = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] phase_M = 11'd500;
   logic [10:0] signal_A = 11'd1200;
   logic [1:0]  signal_shape = 2'd2;
   logic        sample_tick = 1'b0;
   logic [11:0] rom_addr;
   logic [11:0] rom_data = '0;
   logic [11:0] dac_data;
   logic        dac_valid;
   logic        dac_ready = 1'b1;
   logic        phase_wrap;
   logic        sample_overrun;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, last = -100;
   int m_acc, m_M, m_A, m_shape, m_wrap, m_ovr, m_dv, m_dd;
   int q_due[$], q_val[$];
   int acc_seen, wrap_seen;

   always #5 clk = ~clk;

   dds_waveform_gen #(.PHASE_BIT(12), .DAC_BIT(12)) dut (
      .clk(clk), .rst(rst), .phase_M(phase_M), .signal_A(signal_A),
      .signal_shape(signal_shape), .sample_tick(sample_tick), .rom_addr(rom_addr),
      .rom_data(rom_data), .dac_data(dac_data), .dac_valid(dac_valid),
      .dac_ready(dac_ready), .phase_wrap(phase_wrap), .sample_overrun(sample_overrun)
   );

   function automatic int rom_fn(int a);
      return a == 500 ? 1000 : ((a * 1237) % 4095) - AMAX;
   endfunction

   always @(posedge clk) rom_data <= 12'(rom_fn(int'(rom_addr)));

   function automatic int exp_sample(int p, int a, int s);
      int w, prod, q;
      w = s == 0 ? rom_fn(p) :
          s == 1 ? 2 * (p < HALF ? p : MOD - 1 - p) - AMAX :
          s == 2 ? (p < HALF ? AMAX : -AMAX) : 0;
      prod = w * a;
      q = prod / HALF;
      if (prod < 0 && q * HALF != prod) q = q - 1;
      return HALF + q;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ok, carry, load;
      int sum, pa, ps;
      cyc++;
      if (rst) begin
         m_acc = 0; m_M = 0; m_A = 0; m_shape = 0; m_wrap = 0; m_ovr = 0;
         m_dv = 0; m_dd = HALF; last = -100;
         q_due.delete(); q_val.delete();
         return;
      end
      ok = sample_tick && (cyc - last >= 3) && (m_dv == 0 || dac_ready);
      pa = m_A; ps = m_shape; carry = 0;
      if (ok) begin
         sum = m_acc + m_M;
         carry = sum >= MOD;
         m_acc = sum % MOD;
         q_due.push_back(cyc + 2);
         q_val.push_back(exp_sample(m_acc, pa, ps));
         last = cyc;
      end
      m_wrap = int'(ok && carry);
      if (sample_tick && !ok) m_ovr = 1;
`ifdef DDS_SYNC_UPDATE_EN
      load = (m_M == 0) || (m_wrap == 1);
`else
      load = (m_M == 0) || ok;
`endif
      if (load) begin
         m_M = int'(phase_M); m_A = int'(signal_A); m_shape = int'(signal_shape);
      end
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         m_dv = 1;
         m_dd = q_val.pop_front();
         void'(q_due.pop_front());
      end else if (dac_ready) m_dv = 0;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("acc", int'(rom_addr), m_acc);
      check("wrap", int'(phase_wrap), m_wrap);
      check("overrun", int'(sample_overrun), m_ovr);
      check("valid", int'(dac_valid), m_dv);
      check("data", int'(dac_data), m_dd);
   end

   task automatic do_reset(input int m, input int a, input int s);
      @(negedge clk);
      rst = 1'b1; phase_M = 11'(m); signal_A = 11'(a); signal_shape = 2'(s);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse();
      @(negedge clk) sample_tick = 1'b1;
      @(posedge clk) #1 sample_tick = 1'b0;
      acc_seen = int'(rom_addr);
      wrap_seen = int'(phase_wrap);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset(500, 1200, 2);
      check("rst_data", int'(dac_data), 2048);
      check("rst_valid", int'(dac_valid), 0);
      check("rst_acc", int'(rom_addr), 0);
      check("rst_ovr", int'(sample_overrun), 0);
      pulse();
      check("sq_acc", acc_seen, 500);
      check("sq_valid", int'(dac_valid), 1);
      check("sq_first", int'(dac_data), 3247);
      repeat (4) pulse();
      check("sq_acc5", acc_seen, 2500);
      check("sq_neg", int'(dac_data), 848);

      do_reset(500, 1200, 1);
      pulse();
      check("tri", int'(dac_data), 1434);
      do_reset(500, 0, 1);
      pulse();
      check("tri_a0", int'(dac_data), 2048);

      do_reset(500, 1200, 2);
      @(posedge clk) #1 phase_M = 11'd1000;
`ifdef DDS_SYNC_UPDATE_EN
      repeat (8) pulse();
      check("pre_wrap", wrap_seen, 0);
      pulse();
      check("wrap_acc", acc_seen, 404);
      check("wrap_pulse", wrap_seen, 1);
      pulse();
      check("post_wrap", acc_seen, 1404);
`else
      pulse();
      check("upd_acc1", acc_seen, 500);
      pulse();
      check("upd_acc2", acc_seen, 1500);
`endif

      do_reset(500, 2047, 0);
      pulse();
      check("sine_addr", acc_seen, 500);
      check("sine", int'(dac_data), 3047);

      do_reset(500, 1200, 2);
      pulse();
      dac_ready = 1'b0;
      pulse();
      check("bp_ovr", int'(sample_overrun), 1);
      check("bp_acc", acc_seen, 500);
      check("bp_hold", int'(dac_valid), 1);
      dac_ready = 1'b1;
      pulse();
      check("bp_resume", acc_seen, 1000);

      @(negedge clk) sample_tick = 1'b1;
      @(posedge clk) #1 sample_tick = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("mid_data", int'(dac_data), 2048);
      check("mid_acc", int'(rom_addr), 0);
      check("mid_ovr", int'(sample_overrun), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk) #1;
         check("mid_valid", int'(dac_valid), 0);
      end

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) == 0);
         sample_tick = ($urandom_range(0, 2) == 0);
         dac_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) phase_M = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
         if ($urandom_range(0, 15) == 0) signal_A = 11'($urandom);
         if ($urandom_range(0, 15) == 0) signal_shape = 2'($urandom);
      end
      @(negedge clk);
      rst = 1'b0; sample_tick = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
